// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared byte-lane memory port: fetch (port 0) and data (port 1).
// One transaction at a time, MEM_LATENCY cycles on the port, then a one-cycle valid pulse.
module mem_port_arbiter #(
   parameter int unsigned MEM_LATENCY = 4,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   if_req,
   input  logic [ADDR_W-1:0]      if_addr,
   output logic                   if_gnt,
   output logic                   if_valid,
   output logic [31:0]            if_rdata,
   input  logic                   d_req,
   input  logic                   d_we,
   input  logic [ADDR_W-1:0]      d_addr,
   input  logic [31:0]            d_wdata,
   output logic                   d_gnt,
   output logic                   d_valid,
   output logic [31:0]            d_rdata,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [0:3][7:0]        mem_data_in,
   input  logic [0:3][7:0]        mem_data_out,
   output logic                   mem_write_en,
   output logic                   busy
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

   localparam logic       OwnFetch = 1'b0;
   localparam logic [3:0] CntLast  = 4'(MEM_LATENCY - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        last_gnt;
   logic        owner;
   logic        we_lat;
   logic [31:0] rd_word;

   // Grants are combinational and only offered from IDLE; a tie goes to whoever did not win last.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (state == StIdle && !rst_b) begin
         if (if_req && d_req) begin
            if (last_gnt == OwnFetch) d_gnt = 1'b1;
            else                      if_gnt = 1'b1;
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < 4; k++) rd_word[8*k +: 8] = mem_data_out[k];
   end

   assign busy = (state != StIdle);

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state        <= StIdle;
         cnt          <= '0;
         last_gnt     <= OwnFetch;
         owner        <= OwnFetch;
         we_lat       <= 1'b0;
         mem_addr     <= '0;
         mem_data_in  <= '0;
         mem_write_en <= 1'b0;
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         if_rdata     <= '0;
         d_rdata      <= '0;
      end else begin
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         mem_write_en <= 1'b0;
         case (state)
            StIdle: begin
               if (if_gnt || d_gnt) begin
                  state    <= StBusy;
                  cnt      <= '0;
                  owner    <= d_gnt;
                  last_gnt <= d_gnt;
                  mem_addr <= d_gnt ? d_addr : if_addr;
                  we_lat   <= d_gnt & d_we;
                  // Registered strobe lands in the first BUSY cycle only.
                  mem_write_en <= d_gnt & d_we;
                  for (int k = 0; k < 4; k++) begin
                     mem_data_in[k] <= d_gnt ? d_wdata[8*k +: 8] : 8'h00;
                  end
               end
            end
            StBusy: begin
               if (cnt == CntLast) begin
                  state <= StResp;
                  if (!we_lat) begin
                     if (owner == OwnFetch) if_rdata <= rd_word;
                     else                   d_rdata  <= rd_word;
                  end
                  if (owner == OwnFetch) if_valid <= 1'b1;
                  else                   d_valid  <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            StResp:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level timing model.
module tb_mem_port_arbiter;

   localparam int L = 4;

   logic clk = 1'b0;
   logic rst_b = 1'b1;

   logic            if_req = 1'b0;
   logic [31:0]     if_addr = '0;
   logic            if_gnt, if_valid;
   logic [31:0]     if_rdata;
   logic            d_req = 1'b0, d_we = 1'b0;
   logic [31:0]     d_addr = '0, d_wdata = '0;
   logic            d_gnt, d_valid;
   logic [31:0]     d_rdata;
   logic [31:0]     mem_addr;
   logic [0:3][7:0] mem_data_in, mem_data_out;
   logic            mem_write_en, busy;
   logic [31:0]     mem_w;

   logic            u1_if_req = 1'b0;
   logic [31:0]     u1_if_addr = '0;
   logic            u1_if_gnt, u1_if_valid;
   logic [31:0]     u1_if_rdata;
   logic            u1_d_req = 1'b0, u1_d_we = 1'b0;
   logic [31:0]     u1_d_addr = '0, u1_d_wdata = '0;
   logic            u1_d_gnt, u1_d_valid;
   logic [31:0]     u1_d_rdata;
   logic [31:0]     u1_mem_addr;
   logic [0:3][7:0] u1_mem_data_in, u1_mem_data_out;
   logic            u1_mem_write_en, u1_busy;
   logic [31:0]     u1_mem_w;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] pack(input logic [0:3][7:0] l);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = l[k];
      return w;
   endfunction

   assign mem_w    = memf(mem_addr);
   assign u1_mem_w = memf(u1_mem_addr);
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         mem_data_out[k]    = mem_w[8*k +: 8];
         u1_mem_data_out[k] = u1_mem_w[8*k +: 8];
      end
   end

   mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(32)) dut (
      .clk(clk), .rst_b(rst_b),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
      .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_write_en(mem_write_en), .busy(busy)
   );

   mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
      .clk(clk), .rst_b(rst_b),
      .if_req(u1_if_req), .if_addr(u1_if_addr), .if_gnt(u1_if_gnt), .if_valid(u1_if_valid),
      .if_rdata(u1_if_rdata),
      .d_req(u1_d_req), .d_we(u1_d_we), .d_addr(u1_d_addr), .d_wdata(u1_d_wdata),
      .d_gnt(u1_d_gnt), .d_valid(u1_d_valid), .d_rdata(u1_d_rdata),
      .mem_addr(u1_mem_addr), .mem_data_in(u1_mem_data_in), .mem_data_out(u1_mem_data_out),
      .mem_write_en(u1_mem_write_en), .busy(u1_busy)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Transaction-level model: one grant occupies the port for cycles T+1..T+L+1.
   int          cyc, free_at, t_gnt;
   bit          inflight, m_owner, m_we, m_last;
   logic [31:0] m_addr, m_wdata, x_ir, x_dr;
   bit          e_ig, e_dg;
   bit          s_ig, s_dg, s_busy, s_we, s_iv, s_dv;
   logic [31:0] s_addr, s_ir, s_dr, s_din;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc = 0; free_at = 0; inflight = 0; m_last = 0; x_ir = '0; x_dr = '0;
   endtask

   // Called at posedge+1 with this cycle's inputs applied; returns at the next posedge+1.
   task automatic tick();
      bit e_busy, e_wen, e_val;
      e_ig = 0;
      e_dg = 0;
      if (!rst_b && cyc >= free_at && (if_req || d_req)) begin
         if (if_req && d_req) begin
            e_dg = !m_last;
            e_ig = m_last;
         end else begin
            e_ig = if_req;
            e_dg = d_req;
         end
         inflight = 1; t_gnt = cyc; m_owner = e_dg; m_we = e_dg && d_we;
         m_addr = e_dg ? d_addr : if_addr; m_wdata = d_wdata; m_last = e_dg;
         free_at = cyc + L + 2;
      end
      e_busy = inflight && cyc > t_gnt && cyc <= t_gnt + L + 1;
      e_wen  = inflight && m_we && cyc == t_gnt + 1;
      e_val  = inflight && cyc == t_gnt + L + 1;
      if (e_val && !m_we) begin
         if (m_owner) x_dr = memf(m_addr);
         else         x_ir = memf(m_addr);
      end
      @(negedge clk);
      s_ig = if_gnt; s_dg = d_gnt; s_busy = busy; s_we = mem_write_en;
      s_iv = if_valid; s_dv = d_valid; s_addr = mem_addr; s_ir = if_rdata; s_dr = d_rdata;
      s_din = pack(mem_data_in);
      check("if_gnt", 32'(s_ig), 32'(e_ig));
      check("d_gnt", 32'(s_dg), 32'(e_dg));
      check("busy", 32'(s_busy), 32'(e_busy));
      check("mem_write_en", 32'(s_we), 32'(e_wen));
      check("if_valid", 32'(s_iv), 32'(e_val && !m_owner));
      check("d_valid", 32'(s_dv), 32'(e_val && m_owner));
      check("if_rdata", s_ir, x_ir);
      check("d_rdata", s_dr, x_dr);
      if (e_busy) check("mem_addr", s_addr, m_addr);
      if (e_busy && m_we) check("mem_data_in", s_din, m_wdata);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_b = 1'b1; if_req = 1'b1; d_req = 1'b1;
      #3;
      check("rst_if_gnt", 32'(if_gnt), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wen", 32'(mem_write_en), 32'd0);
      check("rst_valid", 32'({if_valid, d_valid}), 32'd0);
      check("rst_rdata", if_rdata | d_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_data_in", pack(mem_data_in), 32'd0);
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      model_reset();
   endtask

   initial begin
      apply_reset();

      // Single fetch from 0x100.
      for (int c = 0; c < 7; c++) begin
         if_req = (c == 0); if_addr = 32'h100;
         tick();
         check("t1_if_gnt", 32'(s_ig), 32'(c == 0));
         if (c >= 1 && c <= 4) check("t1_mem_addr", s_addr, 32'h100);
         check("t1_if_valid", 32'(s_iv), 32'(c == 5));
         if (c == 5) check("t1_if_rdata", s_ir, 32'hDEADBEEF);
      end

      // Data write.
      for (int c = 0; c < 7; c++) begin
         d_req = (c == 0); d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h11223344;
         tick();
         check("t2_d_gnt", 32'(s_dg), 32'(c == 0));
         check("t2_wen", 32'(s_we), 32'(c == 1));
         if (c == 1) check("t2_data_in", s_din, 32'h11223344);
         check("t2_d_valid", 32'(s_dv), 32'(c == 5));
         if (c == 5) check("t2_d_rdata", s_dr, 32'h0);
      end
      d_we = 1'b0;

      // Both requests held continuously: D,F,D,F every 6 cycles.
      apply_reset();
      for (int c = 0; c < 24; c++) begin
         if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_addr = 32'h3000;
         tick();
         check("t3_d_gnt", 32'(s_dg), 32'(c == 0 || c == 12));
         check("t3_if_gnt", 32'(s_ig), 32'(c == 6 || c == 18));
         check("t3_one_gnt", 32'(s_ig & s_dg), 32'd0);
         check("t3_d_valid", 32'(s_dv), 32'(c == 5 || c == 17));
         check("t3_if_valid", 32'(s_iv), 32'(c == 11 || c == 23));
      end
      if_req = 1'b0; d_req = 1'b0;

      // Reset in the middle of a write's strobe cycle.
      apply_reset();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = $urandom;
      tick();
      d_req = 1'b0;
      #1;
      check("t5_wen_before", 32'(mem_write_en), 32'd1);
      rst_b = 1'b1;
      #1;
      check("t5_wen_async", 32'(mem_write_en), 32'd0);
      check("t5_busy_async", 32'(busy), 32'd0);
      check("t5_no_valid", 32'(d_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      model_reset();
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      tick();
      check("t5_tie_d_gnt", 32'(s_dg), 32'd1);
      d_req = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (e_ig) if_req = 1'b0;
      end

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if (!if_req && $urandom_range(3) == 0) begin
            if_req = 1'b1; if_addr = $urandom & 32'hFFFC;
         end else if (if_req && $urandom_range(15) == 0) begin
            if_req = 1'b0;
         end
         if (!d_req && $urandom_range(3) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom & 32'hFFFC;
            d_wdata = $urandom;
         end else if (d_req && $urandom_range(15) == 0) begin
            d_req = 1'b0;
         end
         tick();
         if (e_ig) if_req = 1'b0;
         if (e_dg) d_req = 1'b0;
      end
      if_req = 1'b0; d_req = 1'b0;
      for (int c = 0; c < 8; c++) tick();

      // MEM_LATENCY = 1 instance: grant at 0, BUSY at 1, valid at 2.
      @(posedge clk);
      #1;
      u1_if_req = 1'b1; u1_if_addr = 32'h40;
      @(negedge clk);
      check("l1_gnt", 32'(u1_if_gnt), 32'd1);
      check("l1_busy0", 32'(u1_busy), 32'd0);
      @(posedge clk);
      #1;
      u1_if_req = 1'b0;
      @(negedge clk);
      check("l1_busy1", 32'(u1_busy), 32'd1);
      check("l1_valid1", 32'(u1_if_valid), 32'd0);
      check("l1_wen1", 32'(u1_mem_write_en), 32'd0);
      @(negedge clk);
      check("l1_valid2", 32'(u1_if_valid), 32'd1);
      check("l1_rdata2", u1_if_rdata, memf(32'h40));
      @(negedge clk);
      check("l1_busy3", 32'(u1_busy), 32'd0);
      check("l1_valid3", 32'(u1_if_valid), 32'd0);
      check("l1_d_side", 32'({u1_d_gnt, u1_d_valid, u1_if_gnt}), 32'd0);
      check("l1_d_rdata", u1_d_rdata, 32'd0);
      check("l1_data_in", pack(u1_mem_data_in), 32'd0);
      check("l1_mem_addr", u1_mem_addr, 32'h40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single byte-lane memory port between two requesters: instruction fetch (port 0) and the data cache fill/write path (port 1). It grants one transaction at a time and holds the memory port for a fixed `MEM_LATENCY` cycles. It then returns read data with a one-cycle valid pulse, which replaces the ad-hoc 5-cycle stall counter in the core. It sits between the core/cache and the external memory model.

## Interface
- `MEM_LATENCY`, default 4: cycles the memory port is held per transaction; legal range 1..15.
- `ADDR_W`, default 32: address width.

- `clk`  in  1: single clock, rising edge.
- `rst_b`  in  1: asynchronous, active-high reset (asserted = 1).
- `if_req`  in  1: fetch request, level; held until `if_gnt`.
- `if_addr`  in  ADDR_W: fetch byte address.
- `if_gnt`  out  1: fetch granted (combinational, IDLE only).
- `if_valid`  out  1: one-cycle fetch completion pulse.
- `if_rdata`  out  32: fetch read data, valid with `if_valid`.
- `d_req`  in  1: data request, level; held until `d_gnt`.
- `d_we`  in  1: 1 = write, 0 = read.
- `d_addr`  in  ADDR_W: data byte address.
- `d_wdata`  in  32: write data; byte k = bits [8k+7:8k].
- `d_gnt`  out  1: data granted.
- `d_valid`  out  1: one-cycle data completion pulse, for reads and writes.
- `d_rdata`  out  32: data read result.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_data_in`  out  8 x [0:3]: write bytes to memory; lane k = `d_wdata`[8k+7:8k].
- `mem_data_out`  in  8 x [0:3]: read bytes from memory; lane k goes to rdata[8k+7:8k].
- `mem_write_en`  out  1: memory write strobe.
- `busy`  out  1: state != IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate. Next state BUSY if any grant, else IDLE.
  - BUSY: `cnt` runs 0..MEM_LATENCY-1. Next state RESP when `cnt`==MEM_LATENCY-1.
  - RESP: one cycle. Next state IDLE.
- Arbitration, IDLE only:
  - Exactly one `*_gnt` is asserted, combinationally, in the cycle a request is seen.
  - Only one requester: grant it.
  - Both requesting: grant the one not recorded in `last_gnt`.
  - `last_gnt` resets to fetch, so the first tie goes to data.
  - `last_gnt` updates on every grant.
- On grant, latch the winner's addr, we (fetch is always read), wdata and owner id.
- During BUSY and RESP:
  - `mem_addr` and `mem_data_in` come from the latched values.
  - Requester inputs are ignored.
- `mem_write_en` is 1 only in BUSY with `cnt`==0 and latched we=1. This gives exactly one write strobe per transaction.
- End of the last BUSY cycle:
  - Reads: register `mem_data_out` into the owner's rdata.
  - Writes: the owner's rdata is unchanged.
- RESP: the owner's `*_valid` = 1 for exactly one cycle.
- A requester may drop `req` after `gnt`. Dropping `req` before `gnt` withdraws the request with no side effect.
- No grants are issued in BUSY or RESP. A request held through these states is granted in the following IDLE cycle.
- `cnt` is 4 bits. It clears on entering BUSY and never wraps past MEM_LATENCY-1.

## Timing
- Reset values: state IDLE, `cnt` 0, `last_gnt` fetch, `mem_addr` 0, `mem_data_in` all 0, `mem_write_en` 0, both `gnt` 0, both `valid` 0, both rdata 0, `busy` 0.
- Latency, with the grant at cycle T:
  - BUSY spans cycles T+1..T+MEM_LATENCY.
  - Valid pulses at T+MEM_LATENCY+1.
- Throughput: one transaction per MEM_LATENCY+2 cycles. Back-to-back grants are spaced MEM_LATENCY+2 apart.
- Reset asserted mid-transaction:
  - All state and outputs return to reset values immediately (asynchronous).
  - `mem_write_en` drops without waiting for a clock.
  - The in-flight transaction is dropped and no valid is issued.
  - After reset deasserts, operation resumes from IDLE on the next rising edge.
- A request and reset deassertion in the same cycle: the grant is issued combinationally in that cycle.

## Test plan
- Single fetch, MEM_LATENCY=4: `if_req`=1, `if_addr`=0x100 at cycle 0; memory returns bytes EF,BE,AD,DE.
  - `if_gnt`=1 at cycle 0.
  - `mem_addr`=0x100 in cycles 1-4.
  - `if_valid`=1 at cycle 5 only, with `if_rdata`=0xDEADBEEF.
- Data write: `d_we`=1, `d_addr`=0x2000, `d_wdata`=0x11223344.
  - `mem_write_en`=1 at cycle 1 only.
  - `mem_data_in` lanes = 44,33,22,11.
  - `d_valid` at cycle 5; `d_rdata` unchanged.
- Both requests held from cycle 0 after reset:
  - `d_gnt` at cycle 0, `if_gnt` at cycle 6.
  - `d_valid` at cycle 5, `if_valid` at cycle 11.
- Both requests held continuously for 4 transactions: grant order D,F,D,F, grants spaced 6 cycles apart, never two grants in one cycle.
- Reset asserted at cycle 1 of a write, mid-cycle:
  - `mem_write_en` and `busy` go to 0 immediately.
  - No `d_valid`.
  - After release, a tied request grants data first.
- MEM_LATENCY=1, fetch read at cycle 0: BUSY at cycle 1 only, `if_valid` at cycle 2.
